// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: execute-phase controller for the SAP-2 arithmetic/logic path.
// Takes one ALU command at a time over a valid/ready handshake. Each command
// moves through three states:
//   IDLE - accept the command and latch the operand,
//   EXEC - run the ALU and register the result,
//   WB   - write back to the accumulator and update the flags.
// The controller owns the accumulator and the Z/S/CY flags.

// ---------------------------------------------------------------------------
// alu: purely combinational 8-bit ALU with carry in and carry out.
// For SUB, cout is the borrow. For rotates, cin is the bit shifted in.
// ---------------------------------------------------------------------------
module alu (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] op,
    input  logic       cin,
    output logic [7:0] y,
    output logic       cout
);

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_NOT   = 4'h5;
    localparam logic [3:0] OP_INC   = 4'h6;
    localparam logic [3:0] OP_DEC   = 4'h7;
    localparam logic [3:0] OP_RAL   = 4'h8;
    localparam logic [3:0] OP_RAR   = 4'h9;
    localparam logic [3:0] OP_PASSA = 4'hA;
    localparam logic [3:0] OP_PASSB = 4'hB;

    logic [7:0] and_v;
    logic [7:0] or_v;
    logic [7:0] xor_v;
    logic [7:0] not_v;
    logic [8:0] sum_v;
    logic [8:0] diff_v;
    logic [8:0] inc_v;
    logic [8:0] dec_v;

    // Bitwise logic results, one lane per bit.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            assign and_v[gi] = a[gi] & b[gi];
            assign or_v[gi]  = a[gi] | b[gi];
            assign xor_v[gi] = a[gi] ^ b[gi];
            assign not_v[gi] = ~a[gi];
        end
    endgenerate

    // In the 9-bit adders, bit 8 is the carry. In the subtractor, the
    // 9-bit wrap leaves bit 8 set exactly when a borrow occurred.
    assign sum_v  = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    assign diff_v = {1'b0, a} - {1'b0, b} - {8'd0, cin};
    assign inc_v  = {1'b0, a} + 9'd1;
    assign dec_v  = {1'b0, a} - 9'd1;

    // Select the result and carry for the requested operation.
    always_comb begin
        y    = a;
        cout = 1'b0;
        case (op)
            OP_ADD:   begin y = sum_v[7:0];    cout = sum_v[8];  end
            OP_SUB:   begin y = diff_v[7:0];   cout = diff_v[8]; end
            OP_AND:   begin y = and_v;         cout = 1'b0;      end
            OP_OR:    begin y = or_v;          cout = 1'b0;      end
            OP_XOR:   begin y = xor_v;         cout = 1'b0;      end
            OP_NOT:   begin y = not_v;         cout = 1'b0;      end
            OP_INC:   begin y = inc_v[7:0];    cout = inc_v[8];  end
            OP_DEC:   begin y = dec_v[7:0];    cout = dec_v[8];  end
            OP_RAL:   begin y = {a[6:0], cin}; cout = a[7];      end
            OP_RAR:   begin y = {cin, a[7:1]}; cout = a[0];      end
            OP_PASSA: begin y = a;             cout = 1'b0;      end
            OP_PASSB: begin y = b;             cout = 1'b0;      end
            // Illegal opcodes pass A through. The controller discards
            // the result anyway.
            default:  begin y = a;             cout = 1'b0;      end
        endcase
    end

endmodule

// ---------------------------------------------------------------------------
// alu_exec_ctrl: command sequencer, accumulator and flag owner.
// ---------------------------------------------------------------------------
module alu_exec_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_operand,
    input  logic       cmd_use_carry,
    input  logic       cmd_nowb,
    output logic [7:0] acc_out,
    output logic       flag_z,
    output logic       flag_s,
    output logic       flag_cy,
    output logic       done,
    output logic       err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_INC   = 4'h6;
    localparam logic [3:0] OP_DEC   = 4'h7;
    localparam logic [3:0] OP_RAL   = 4'h8;
    localparam logic [3:0] OP_RAR   = 4'h9;
    localparam logic [3:0] OP_LAST  = 4'hB;

    logic [1:0] state_q,     state_d;
    logic [3:0] op_q,        op_d;
    logic [7:0] tmp_q,       tmp_d;
    logic       use_carry_q, use_carry_d;
    logic       nowb_q,      nowb_d;
    logic [8:0] res_q,       res_d;
    logic [7:0] acc_q,       acc_d;
    logic       z_q,         z_d;
    logic       s_q,         s_d;
    logic       cy_q,        cy_d;
    logic       done_q,      done_d;
    logic       err_q,       err_d;

    logic       accept;
    logic       op_legal;
    logic       alu_cin;
    logic [7:0] alu_y;
    logic       alu_cout;

    // Ready is held low for as long as reset is asserted, not only after it.
    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign op_legal  = (op_q <= OP_LAST);

    // Rotates always shift CY in. ADD and SUB use CY only when the
    // command asked for carry (ADC/SBB).
    always_comb begin
        alu_cin = 1'b0;
        case (op_q)
            OP_RAL, OP_RAR: alu_cin = cy_q;
            OP_ADD, OP_SUB: alu_cin = use_carry_q & cy_q;
            default:        alu_cin = 1'b0;
        endcase
    end

    alu u_alu (
        .a    (acc_q),
        .b    (tmp_q),
        .op   (op_q),
        .cin  (alu_cin),
        .y    (alu_y),
        .cout (alu_cout)
    );

    // Next-state logic: state sequencing, command latch and result register.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        tmp_d       = tmp_q;
        use_carry_d = use_carry_q;
        nowb_d      = nowb_q;
        res_d       = res_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d        = cmd_op;
                    tmp_d       = cmd_operand;
                    use_carry_d = cmd_use_carry;
                    nowb_d      = cmd_nowb;
                    state_d     = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d   = {alu_cout, alu_y};
                state_d = ST_WB;
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write-back logic: accumulator, flags by op class, and the done/err pulse.
    always_comb begin
        acc_d  = acc_q;
        z_d    = z_q;
        s_d    = s_q;
        cy_d   = cy_q;
        done_d = 1'b0;
        err_d  = 1'b0;
        if (state_q == ST_WB) begin
            done_d = 1'b1;
            err_d  = !op_legal;
            if (op_legal && !nowb_q) begin
                acc_d = res_q[7:0];
            end
            case (op_q)
                OP_ADD, OP_SUB: begin
                    z_d  = (res_q[7:0] == 8'h00);
                    s_d  = res_q[7];
                    cy_d = res_q[8];
                end
                OP_AND, OP_OR, OP_XOR: begin
                    z_d  = (res_q[7:0] == 8'h00);
                    s_d  = res_q[7];
                    cy_d = 1'b0;
                end
                OP_INC, OP_DEC: begin
                    z_d  = (res_q[7:0] == 8'h00);
                    s_d  = res_q[7];
                end
                OP_RAL, OP_RAR: begin
                    cy_d = res_q[8];
                end
                // NOT, PASS A/B and illegal opcodes leave the flags alone.
                default: begin
                end
            endcase
        end
    end

    // State and datapath registers. Reset clears everything immediately,
    // which also aborts any command that is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= 4'h0;
            tmp_q       <= 8'h00;
            use_carry_q <= 1'b0;
            nowb_q      <= 1'b0;
            res_q       <= 9'd0;
            acc_q       <= 8'h00;
            z_q         <= 1'b0;
            s_q         <= 1'b0;
            cy_q        <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            tmp_q       <= tmp_d;
            use_carry_q <= use_carry_d;
            nowb_q      <= nowb_d;
            res_q       <= res_d;
            acc_q       <= acc_d;
            z_q         <= z_d;
            s_q         <= s_d;
            cy_q        <= cy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign acc_out = acc_q;
    assign flag_z  = z_q;
    assign flag_s  = s_q;
    assign flag_cy = cy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Testbench for alu_exec_ctrl: directed scenarios followed by random commands.
// Results are checked against an arithmetic model of the accumulator and flags.
module tb_alu_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_operand;
    logic       cmd_use_carry;
    logic       cmd_nowb;
    logic [7:0] acc_out;
    logic       flag_z;
    logic       flag_s;
    logic       flag_cy;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int m_acc = 0;
    int m_z   = 0;
    int m_s   = 0;
    int m_cy  = 0;

    alu_exec_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_operand   (cmd_operand),
        .cmd_use_carry (cmd_use_carry),
        .cmd_nowb      (cmd_nowb),
        .acc_out       (acc_out),
        .flag_z        (flag_z),
        .flag_s        (flag_s),
        .flag_cy       (flag_cy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_acc"}, 16'(acc_out), 16'(m_acc));
        chk({tag, "_z"},   16'(flag_z),  16'(m_z));
        chk({tag, "_s"},   16'(flag_s),  16'(m_s));
        chk({tag, "_cy"},  16'(flag_cy), 16'(m_cy));
    endtask

    // Apply one command to the model, working from the instruction-set rules.
    task automatic model_apply(input int op, input int b, input int uc, input int nb,
                               output int exp_err);
        int a;
        int r;
        int cin;
        int res;
        a       = m_acc;
        res     = a;
        exp_err = 0;
        cin     = (uc != 0) ? m_cy : 0;
        case (op)
            0: begin r = a + b + cin; res = r % 256; m_cy = (r > 255) ? 1 : 0; end
            1: begin r = a - b - cin; res = (r + 512) % 256; m_cy = (r < 0) ? 1 : 0; end
            2: begin res = a & b; m_cy = 0; end
            3: begin res = a | b; m_cy = 0; end
            4: begin res = a ^ b; m_cy = 0; end
            5: res = 255 - a;
            6: res = (a + 1) % 256;
            7: res = (a + 255) % 256;
            8: begin res = (a * 2 + m_cy) % 256; m_cy = (a >= 128) ? 1 : 0; end
            9: begin res = a / 2 + m_cy * 128;   m_cy = a % 2; end
            10: res = a;
            11: res = b;
            default: exp_err = 1;
        endcase
        if (op <= 4 || op == 6 || op == 7) begin
            m_z = (res == 0) ? 1 : 0;
            m_s = (res >= 128) ? 1 : 0;
        end
        if (exp_err == 0 && nb == 0) m_acc = res;
    endtask

    // Issue one command and check every cycle up to and including done.
    // The task is entered between edges with cmd_ready expected high.
    task automatic do_cmd(input logic [3:0] op, input logic [7:0] b,
                          input logic uc, input logic nb);
        int exp_err;
        chk("ready_before", 16'(cmd_ready), 16'd1);
        cmd_valid     = 1'b1;
        cmd_op        = op;
        cmd_operand   = b;
        cmd_use_carry = uc;
        cmd_nowb      = nb;
        @(posedge clk); #1;
        // Scramble the inputs after accept: they must have no effect.
        cmd_valid     = 1'b0;
        cmd_op        = 4'($urandom);
        cmd_operand   = 8'($urandom);
        cmd_use_carry = 1'($urandom);
        cmd_nowb      = 1'($urandom);
        chk("ready_e0", 16'(cmd_ready), 16'd0);
        chk("done_e0",  16'(done),      16'd0);
        check_state("e0");
        @(posedge clk); #1;
        chk("ready_e1", 16'(cmd_ready), 16'd0);
        chk("done_e1",  16'(done),      16'd0);
        check_state("e1");
        @(posedge clk); #1;
        model_apply(int'(op), int'(b), int'(uc), int'(nb), exp_err);
        chk("done_e2",  16'(done),      16'd1);
        chk("err_e2",   16'(err),       16'(exp_err));
        chk("ready_e2", 16'(cmd_ready), 16'd1);
        check_state("wb");
        $display("txn op=%0h b=%02h uc=%0d nb=%0d -> acc=%02h z=%0d s=%0d cy=%0d done=%0d err=%0d",
                 op, b, uc, nb, acc_out, flag_z, flag_s, flag_cy, done, err);
    endtask

    initial begin
        rst           = 1'b1;
        cmd_valid     = 1'b0;
        cmd_op        = 4'h0;
        cmd_operand   = 8'h00;
        cmd_use_carry = 1'b0;
        cmd_nowb      = 1'b0;
        #1;
        chk("rst_ready", 16'(cmd_ready), 16'd0);
        chk("rst_done",  16'(done),      16'd0);
        chk("rst_err",   16'(err),       16'd0);
        check_state("rst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("rel_ready", 16'(cmd_ready), 16'd1);

        // Load and add.
        do_cmd(4'hB, 8'h3C, 1'b0, 1'b0);
        do_cmd(4'h0, 8'h05, 1'b0, 1'b0);
        chk("plan_add_acc", 16'(acc_out), 16'h41);
        // Carry chain.
        do_cmd(4'hB, 8'hFF, 1'b0, 1'b0);
        do_cmd(4'h0, 8'h01, 1'b0, 1'b0);
        chk("plan_carry_z",  16'(flag_z),  16'd1);
        chk("plan_carry_cy", 16'(flag_cy), 16'd1);
        do_cmd(4'h0, 8'h00, 1'b1, 1'b0);
        chk("plan_adc_acc", 16'(acc_out), 16'h01);
        // Compare and logic.
        do_cmd(4'hB, 8'h10, 1'b0, 1'b0);
        do_cmd(4'h1, 8'h20, 1'b0, 1'b1);
        chk("plan_cmp_acc", 16'(acc_out), 16'h10);
        chk("plan_cmp_s",   16'(flag_s),  16'd1);
        do_cmd(4'h2, 8'h0F, 1'b0, 1'b0);
        chk("plan_and_z", 16'(flag_z), 16'd1);
        // Rotate and INC/DEC.
        do_cmd(4'hB, 8'h81, 1'b0, 1'b0);
        do_cmd(4'h8, 8'h00, 1'b0, 1'b0);
        chk("plan_ral_acc", 16'(acc_out), 16'h02);
        do_cmd(4'h9, 8'h00, 1'b0, 1'b0);
        chk("plan_rar_acc", 16'(acc_out), 16'h81);
        do_cmd(4'hB, 8'h00, 1'b0, 1'b0);
        do_cmd(4'h7, 8'h00, 1'b0, 1'b0);
        chk("plan_dec_acc", 16'(acc_out), 16'hFF);
        do_cmd(4'h6, 8'h00, 1'b0, 1'b0);
        chk("plan_inc_wrap_z", 16'(flag_z), 16'd1);
        // Illegal opcode.
        do_cmd(4'hD, 8'h55, 1'b0, 1'b0);
        chk("plan_illegal_err", 16'(err), 16'd1);

        // cmd_valid held high: one accept every 3 cycles, none while busy.
        cmd_valid     = 1'b1;
        cmd_op        = 4'h6;
        cmd_operand   = 8'h00;
        cmd_use_carry = 1'b0;
        cmd_nowb      = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("hold_ready", 16'(cmd_ready), 16'd1);
            @(posedge clk); #1;
            chk("hold_busy0", 16'(cmd_ready), 16'd0);
            @(posedge clk); #1;
            chk("hold_busy1", 16'(cmd_ready), 16'd0);
            chk("hold_nodone", 16'(done), 16'd0);
            @(posedge clk); #1;
            m_acc = (m_acc + 1) % 256;
            m_z   = (m_acc == 0) ? 1 : 0;
            m_s   = (m_acc >= 128) ? 1 : 0;
            chk("hold_done", 16'(done), 16'd1);
            check_state("hold");
            $display("txn held-valid INC #%0d -> acc=%02h", k, acc_out);
        end
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("hold_end_done",  16'(done),      16'd0);
        chk("hold_end_ready", 16'(cmd_ready), 16'd1);

        // Random commands.
        for (int i = 0; i < 60; i++) begin
            do_cmd(4'($urandom_range(0, 15)), 8'($urandom), 1'($urandom), 1'($urandom));
        end

        // Reset in the middle of EXEC aborts the command.
        do_cmd(4'hB, 8'hA5, 1'b0, 1'b0);
        do_cmd(4'h0, 8'h80, 1'b0, 1'b0);
        cmd_valid   = 1'b1;
        cmd_op      = 4'h0;
        cmd_operand = 8'h11;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        m_acc = 0; m_z = 0; m_s = 0; m_cy = 0;
        chk("midrst_ready", 16'(cmd_ready), 16'd0);
        chk("midrst_done",  16'(done),      16'd0);
        check_state("midrst");
        @(posedge clk); #1;
        chk("midrst_done2", 16'(done), 16'd0);
        rst = 1'b0;
        #1 chk("midrst_rel_ready", 16'(cmd_ready), 16'd1);
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            chk("midrst_nodone", 16'(done), 16'd0);
            check_state("midrst_after");
        end
        $display("txn reset during EXEC -> acc=%02h done=%0d", acc_out, done);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
